// File: rtl/fma_operand_sequencer.sv
// Operand sequencer for the FMA: captures an (a, b, c) triple, streams it as a
// start-tagged three-beat burst, then holds the FMA outcome under valid/ready.
module fma_operand_sequencer #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        op_valid_in,
    output logic        op_ready_out,
    input  logic [31:0] op_a_in,
    input  logic [31:0] op_b_in,
    input  logic [31:0] op_c_in,
    output logic        fma_start_out,
    output logic [31:0] fma_data_out,
    input  logic        fma_ready_in,
    input  logic        fma_error_in,
    input  logic [31:0] fma_result_in,
    output logic        res_valid_out,
    input  logic        res_ready_in,
    output logic [31:0] res_data_out,
    output logic [1:0]  res_status_out
);

    localparam int unsigned     CNT_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0]  ST_OK      = 2'd0;
    localparam logic [1:0]  ST_FMA_ERR = 2'd1;
    localparam logic [1:0]  ST_TIMEOUT = 2'd2;
    localparam logic [1:0]  ST_BAD_OP  = 2'd3;
    localparam logic [31:0] ERR_DATA   = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        S_IDLE, S_SEND_A, S_SEND_B, S_SEND_C, S_WAIT, S_HOLD
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      a_q, a_d, b_q, b_d, c_q, c_d;
    logic [31:0]      res_data_q, res_data_d;
    logic [1:0]       res_status_q, res_status_d;
    logic             res_valid_q, res_valid_d;
    logic             start_q, start_d;
    logic [31:0]      data_q, data_d;

    // Denormals and Inf/NaN are rejected before anything reaches the FMA.
    function automatic logic is_bad(input logic [31:0] f);
        return (&f[30:23]) | ((~|f[30:23]) & (|f[22:0]));
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            a_q          <= '0;
            b_q          <= '0;
            c_q          <= '0;
            res_data_q   <= '0;
            res_status_q <= ST_OK;
            res_valid_q  <= 1'b0;
            start_q      <= 1'b0;
            data_q       <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            a_q          <= a_d;
            b_q          <= b_d;
            c_q          <= c_d;
            res_data_q   <= res_data_d;
            res_status_q <= res_status_d;
            res_valid_q  <= res_valid_d;
            start_q      <= start_d;
            data_q       <= data_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        a_d          = a_q;
        b_d          = b_q;
        c_d          = c_q;
        res_data_d   = res_data_q;
        res_status_d = res_status_q;
        unique case (state_q)
            S_IDLE: begin
                if (op_valid_in) begin
                    a_d = op_a_in;
                    b_d = op_b_in;
                    c_d = op_c_in;
                    if (is_bad(op_a_in) || is_bad(op_b_in) || is_bad(op_c_in)) begin
                        state_d      = S_HOLD;
                        res_data_d   = ERR_DATA;
                        res_status_d = ST_BAD_OP;
                    end else begin
                        state_d = S_SEND_A;
                    end
                end
            end
            S_SEND_A: state_d = S_SEND_B;
            S_SEND_B, S_SEND_C: begin
                if (fma_error_in) begin
                    state_d      = S_HOLD;
                    res_data_d   = ERR_DATA;
                    res_status_d = ST_FMA_ERR;
                end else if (state_q == S_SEND_B) begin
                    state_d = S_SEND_C;
                end else begin
                    state_d = S_WAIT;
                    cnt_d   = '0;
                end
            end
            S_WAIT: begin
                // Error outranks ready, and both outrank the timeout on the last cycle.
                if (fma_error_in) begin
                    state_d      = S_HOLD;
                    res_data_d   = ERR_DATA;
                    res_status_d = ST_FMA_ERR;
                end else if (fma_ready_in) begin
                    state_d      = S_HOLD;
                    res_data_d   = fma_result_in;
                    res_status_d = ST_OK;
                end else if (cnt_q == CNT_LAST) begin
                    state_d      = S_HOLD;
                    res_data_d   = ERR_DATA;
                    res_status_d = ST_TIMEOUT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_HOLD: begin
                if (res_ready_in) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Drive values are decoded from the next state so the FMA sees registered lines.
    always_comb begin
        start_d     = (state_d == S_SEND_A);
        res_valid_d = (state_d == S_HOLD);
        unique case (state_d)
            S_SEND_A: data_d = a_d;
            S_SEND_B: data_d = b_d;
            S_SEND_C: data_d = c_d;
            default:  data_d = '0;
        endcase
    end

    assign op_ready_out   = (state_q == S_IDLE);
    assign fma_start_out  = start_q;
    assign fma_data_out   = data_q;
    assign res_valid_out  = res_valid_q;
    assign res_data_out   = res_data_q;
    assign res_status_out = res_status_q;

endmodule

// File: tb/tb_fma_operand_sequencer.sv
// Directed bench for fma_operand_sequencer with a transaction-level reference
// model compared every cycle plus literal spot checks.
module tb_fma_operand_sequencer;

    localparam int TO = 16;

    logic        clk, rst;
    logic        op_valid_in, op_ready_out;
    logic [31:0] op_a_in, op_b_in, op_c_in;
    logic        fma_start_out;
    logic [31:0] fma_data_out;
    logic        fma_ready_in, fma_error_in;
    logic [31:0] fma_result_in;
    logic        res_valid_out, res_ready_in;
    logic [31:0] res_data_out;
    logic [1:0]  res_status_out;

    int tests = 0;
    int fails = 0;

    fma_operand_sequencer #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst),
        .op_valid_in(op_valid_in), .op_ready_out(op_ready_out),
        .op_a_in(op_a_in), .op_b_in(op_b_in), .op_c_in(op_c_in),
        .fma_start_out(fma_start_out), .fma_data_out(fma_data_out),
        .fma_ready_in(fma_ready_in), .fma_error_in(fma_error_in),
        .fma_result_in(fma_result_in),
        .res_valid_out(res_valid_out), .res_ready_in(res_ready_in),
        .res_data_out(res_data_out), .res_status_out(res_status_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic bit bad_op(input logic [31:0] x);
        int e;
        e = int'(x[30:23]);
        return (e == 255) || (e == 0 && x[22:0] != 23'd0);
    endfunction

    // Reference model: a transaction is either absent, in flight (position in
    // cycles since the handshake), or held with its outcome.
    int          cyc, m_hs, pos;
    bit          m_busy, m_hold;
    logic [31:0] m_a, m_b, m_c, m_res;
    logic [1:0]  m_st;

    always_comb pos = cyc - m_hs;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            cyc <= 0; m_hs <= 0; m_busy <= 1'b0; m_hold <= 1'b0;
            m_a <= '0; m_b <= '0; m_c <= '0; m_res <= '0; m_st <= 2'd0;
        end else begin
            cyc <= cyc + 1;
            if (!m_busy) begin
                if (op_valid_in) begin
                    m_busy <= 1'b1;
                    m_a <= op_a_in; m_b <= op_b_in; m_c <= op_c_in;
                    if (bad_op(op_a_in) || bad_op(op_b_in) || bad_op(op_c_in)) begin
                        m_hold <= 1'b1; m_res <= 32'hFFFF_FFFF; m_st <= 2'd3;
                    end else begin
                        m_hold <= 1'b0; m_hs <= cyc + 1;
                    end
                end
            end else if (m_hold) begin
                if (res_ready_in) begin m_busy <= 1'b0; m_hold <= 1'b0; end
            end else if (pos >= 1 && fma_error_in) begin
                m_hold <= 1'b1; m_res <= 32'hFFFF_FFFF; m_st <= 2'd1;
            end else if (pos >= 3 && fma_ready_in) begin
                m_hold <= 1'b1; m_res <= fma_result_in; m_st <= 2'd0;
            end else if (pos == TO + 2) begin
                m_hold <= 1'b1; m_res <= 32'hFFFF_FFFF; m_st <= 2'd2;
            end
        end
    end

    logic        e_ready, e_start, e_valid;
    logic [31:0] e_data;
    always_comb begin
        e_ready = !m_busy;
        e_valid = m_busy && m_hold;
        e_start = m_busy && !m_hold && pos == 0;
        e_data  = 32'd0;
        if (m_busy && !m_hold) begin
            if (pos == 0)      e_data = m_a;
            else if (pos == 1) e_data = m_b;
            else if (pos == 2) e_data = m_c;
        end
    end

    always @(posedge clk) begin
        #2;
        if (rst) begin
            chk("model op_ready", 32'(op_ready_out), 32'(e_ready));
            chk("model start", 32'(fma_start_out), 32'(e_start));
            chk("model fma_data", fma_data_out, e_data);
            chk("model res_valid", 32'(res_valid_out), 32'(e_valid));
            if (e_valid) begin
                chk("model res_data", res_data_out, m_res);
                chk("model res_status", 32'(res_status_out), 32'(m_st));
            end
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
        op_valid_in = 1'b1; op_a_in = a; op_b_in = b; op_c_in = c;
        tick();
        op_valid_in = 1'b0;
    endtask

    task automatic release_res();
        res_ready_in = 1'b1;
        tick();
        res_ready_in = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b0; op_valid_in = 1'b0; op_a_in = '0; op_b_in = '0; op_c_in = '0;
        fma_ready_in = 1'b0; fma_error_in = 1'b0; fma_result_in = '0; res_ready_in = 1'b0;
        tick();
        chk("reset op_ready", 32'(op_ready_out), 32'd1);
        chk("reset start", 32'(fma_start_out), 32'd0);
        chk("reset data", fma_data_out, 32'd0);
        chk("reset valid", 32'(res_valid_out), 32'd0);
        chk("reset res_data", res_data_out, 32'd0);
        chk("reset status", 32'(res_status_out), 32'd0);
        rst = 1'b1;
        tick();

        // Normal sum 2*3+1 = 7
        send(32'h4000_0000, 32'h4040_0000, 32'h3F80_0000);
        chk("t1 start", 32'(fma_start_out), 32'd1);
        chk("t1 beat a", fma_data_out, 32'h4000_0000);
        tick();
        chk("t1 beat b", fma_data_out, 32'h4040_0000);
        chk("t1 start b", 32'(fma_start_out), 32'd0);
        tick();
        chk("t1 beat c", fma_data_out, 32'h3F80_0000);
        tick();
        chk("t1 idle line", fma_data_out, 32'd0);
        tick();
        fma_ready_in = 1'b1; fma_result_in = 32'h40E0_0000;
        tick();
        fma_ready_in = 1'b0; fma_result_in = '0;
        chk("t1 valid", 32'(res_valid_out), 32'd1);
        chk("t1 result", res_data_out, 32'h40E0_0000);
        chk("t1 status", 32'(res_status_out), 32'd0);
        release_res();
        chk("t1 back idle", 32'(op_ready_out), 32'd1);

        // Bad operands: Inf and denormal
        for (int i = 0; i < 2; i++) begin
            logic [31:0] bv;
            bv = (i == 0) ? 32'h7F80_0000 : 32'h0000_0001;
            send(32'h3F80_0000, bv, 32'h3F80_0000);
            chk("t2 no start", 32'(fma_start_out), 32'd0);
            chk("t2 valid", 32'(res_valid_out), 32'd1);
            chk("t2 status", 32'(res_status_out), 32'd3);
            chk("t2 data", res_data_out, 32'hFFFF_FFFF);
            release_res();
        end

        // FMA error during SEND_B
        send(32'h3F80_0000, 32'h4000_0000, 32'h4080_0000);
        tick();
        fma_error_in = 1'b1;
        tick();
        fma_error_in = 1'b0;
        chk("t3 line zero", fma_data_out, 32'd0);
        chk("t3 status", 32'(res_status_out), 32'd1);
        chk("t3 data", res_data_out, 32'hFFFF_FFFF);
        tick();
        chk("t3 no c", fma_data_out, 32'd0);
        release_res();

        // Timeout, then a late ready pulse
        send(32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000);
        repeat (3) tick();
        repeat (TO - 1) tick();
        chk("t4 not yet", 32'(res_valid_out), 32'd0);
        tick();
        chk("t4 valid", 32'(res_valid_out), 32'd1);
        chk("t4 status", 32'(res_status_out), 32'd2);
        repeat (3) tick();
        fma_ready_in = 1'b1; fma_result_in = 32'h1234_5678;
        tick();
        fma_ready_in = 1'b0; fma_result_in = '0;
        chk("t4 late data", res_data_out, 32'hFFFF_FFFF);
        chk("t4 late status", 32'(res_status_out), 32'd2);

        // Backpressure while a new triple waits
        op_valid_in = 1'b1; op_a_in = 32'h3FC0_0000; op_b_in = 32'h3F80_0000; op_c_in = 32'h0;
        repeat (5) begin
            tick();
            chk("t5 op_ready", 32'(op_ready_out), 32'd0);
            chk("t5 no start", 32'(fma_start_out), 32'd0);
            chk("t5 stable", res_data_out, 32'hFFFF_FFFF);
        end
        res_ready_in = 1'b1;
        tick();
        res_ready_in = 1'b0;
        chk("t5 idle", 32'(op_ready_out), 32'd1);
        chk("t5 no bypass", 32'(fma_start_out), 32'd0);
        tick();
        op_valid_in = 1'b0;
        chk("t5 accepted", 32'(fma_start_out), 32'd1);
        chk("t5 beat a", fma_data_out, 32'h3FC0_0000);

        // Reset mid-WAIT
        repeat (3) tick();
        #3 rst = 1'b0;
        #1;
        chk("t6 op_ready", 32'(op_ready_out), 32'd1);
        chk("t6 start", 32'(fma_start_out), 32'd0);
        chk("t6 data", fma_data_out, 32'd0);
        chk("t6 valid", 32'(res_valid_out), 32'd0);
        chk("t6 res_data", res_data_out, 32'd0);
        chk("t6 status", 32'(res_status_out), 32'd0);
        tick();
        rst = 1'b1;
        fma_ready_in = 1'b1; fma_result_in = 32'h40E0_0000;
        tick();
        fma_ready_in = 1'b0; fma_result_in = '0;
        chk("t6 pulse ignored", 32'(res_valid_out), 32'd0);

        // Ready on the final WAIT cycle wins over timeout; negative zero is legal
        send(32'h8000_0000, 32'h3F80_0000, 32'h3F80_0000);
        repeat (3) tick();
        repeat (TO - 1) tick();
        fma_ready_in = 1'b1; fma_result_in = 32'h3F80_0000;
        tick();
        fma_ready_in = 1'b0; fma_result_in = '0;
        chk("t7 status", 32'(res_status_out), 32'd0);
        chk("t7 data", res_data_out, 32'h3F80_0000);
        release_res();

        // Error and ready together: error wins
        send(32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000);
        repeat (4) tick();
        fma_error_in = 1'b1; fma_ready_in = 1'b1; fma_result_in = 32'h4000_0000;
        tick();
        fma_error_in = 1'b0; fma_ready_in = 1'b0; fma_result_in = '0;
        chk("t8 status", 32'(res_status_out), 32'd1);
        chk("t8 data", res_data_out, 32'hFFFF_FFFF);
        release_res();

        // Error in SEND_A is ignored
        send(32'h4000_0000, 32'h4040_0000, 32'h4080_0000);
        fma_error_in = 1'b1;
        tick();
        fma_error_in = 1'b0;
        chk("t9 still b", fma_data_out, 32'h4040_0000);
        chk("t9 no hold", 32'(res_valid_out), 32'd0);
        repeat (2) tick();
        fma_ready_in = 1'b1; fma_result_in = 32'h4150_0000;
        tick();
        fma_ready_in = 1'b0; fma_result_in = '0;
        chk("t9 status", 32'(res_status_out), 32'd0);
        chk("t9 data", res_data_out, 32'h4150_0000);
        release_res();
        repeat (3) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
